// File: rtl/freq_meas_pkg.sv
// Shared state encoding and default sizing for the frequency-measurement sequencer.
package freq_meas_pkg;

  localparam int          CNT_W_DEF       = 32;
  localparam int          WD_W            = 32;
  localparam logic [15:0] START_DELAY_DEF = 16'h1111;
  localparam logic [31:0] TIMEOUT_DEF     = 32'd200_000_000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_DLY = 3'd1,
    ST_ARM      = 3'd2,
    ST_RUN      = 3'd3,
    ST_HOLD     = 3'd4
  } state_t;

endpackage

// File: rtl/freq_meas_watchdog.sv
// Saturating run watchdog: clear has priority, counts while enabled, flags the last allowed cycle.
module freq_meas_watchdog
  import freq_meas_pkg::*;
#(
  parameter logic [WD_W-1:0] LIMIT = TIMEOUT_DEF
) (
  input  logic clk_out1,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WD_W-1:0] cnt_r;

  // Run-length counter; sticks at all-ones so it can never wrap back below LIMIT.
  always_ff @(posedge clk_out1 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {WD_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {WD_W{1'b0}};
    end else if (en && (cnt_r != {WD_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(WD_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == (LIMIT - {{(WD_W-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/freq_meas_sequencer.sv
// Schedules repeated measurement runs, snapshots datapath counts into a valid/ready
// result port, and aborts runs whose finished edge never arrives.
module freq_meas_sequencer
  import freq_meas_pkg::*;
#(
  parameter int          CNT_W       = CNT_W_DEF,
  parameter logic [15:0] START_DELAY = START_DELAY_DEF,
  parameter logic [31:0] TIMEOUT     = TIMEOUT_DEF
) (
  input  logic             clk_out1,
  input  logic             rst_n,
  input  logic             enable,
  output logic             meas_start,
  input  logic             meas_busy,
  input  logic             meas_finished,
  input  logic [CNT_W-1:0] time_cnt,
  input  logic [CNT_W-1:0] sig_cnt1,
  input  logic [CNT_W-1:0] sig_cnt2,
  input  logic [CNT_W-1:0] sig_cnt3,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_time,
  output logic [CNT_W-1:0] res_cnt1,
  output logic [CNT_W-1:0] res_cnt2,
  output logic [CNT_W-1:0] res_cnt3,
  output logic [15:0]      run_count,
  output logic             timeout_err,
  output logic             led_on
);

  state_t           state_r, next_state_s;
  logic [15:0]      dly_cnt_r;
  logic             finished_d_r;
  logic             meas_start_r, res_valid_r, timeout_err_r, led_on_r;
  logic [15:0]      run_count_r;
  logic [CNT_W-1:0] res_time_r, res_cnt1_r, res_cnt2_r, res_cnt3_r;

  logic fin_rise_s, dly_done_s, wd_expired_s, accept_s;
  logic capture_s, abort_s, wd_clr_s, wd_en_s;
  logic unused_busy_s;

  // Busy is status-only from the datapath and deliberately plays no part in sequencing.
  assign unused_busy_s = meas_busy;

  assign fin_rise_s = meas_finished & ~finished_d_r;
  assign dly_done_s = (dly_cnt_r == (START_DELAY - 16'd1));
  assign accept_s   = (state_r == ST_HOLD) & res_valid_r & res_ready;

  freq_meas_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
    .clk_out1 (clk_out1),
    .rst_n    (rst_n),
    .clr      (wd_clr_s),
    .en       (wd_en_s),
    .expired  (wd_expired_s)
  );

  // State register.
  always_ff @(posedge clk_out1 or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= next_state_s;
  end

  // Next-state logic; a finished edge beats a same-cycle watchdog expiry.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) next_state_s = ST_WAIT_DLY;
        else        next_state_s = ST_IDLE;
      end
      ST_WAIT_DLY: begin
        if (!enable)        next_state_s = ST_IDLE;
        else if (dly_done_s) next_state_s = ST_ARM;
        else                next_state_s = ST_WAIT_DLY;
      end
      ST_ARM: next_state_s = ST_RUN;
      ST_RUN: begin
        if (fin_rise_s)        next_state_s = ST_HOLD;
        else if (wd_expired_s) next_state_s = ST_WAIT_DLY;
        else                   next_state_s = ST_RUN;
      end
      ST_HOLD: begin
        if (accept_s) next_state_s = enable ? ST_WAIT_DLY : ST_IDLE;
        else          next_state_s = ST_HOLD;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Per-state control strobes for the datapath registers and the watchdog.
  always_comb begin
    capture_s = 1'b0;
    abort_s   = 1'b0;
    wd_clr_s  = 1'b0;
    wd_en_s   = 1'b0;
    case (state_r)
      ST_ARM: wd_clr_s = 1'b1;
      ST_RUN: begin
        wd_en_s = 1'b1;
        if (fin_rise_s) begin
          capture_s = 1'b1;
        end else begin
          abort_s = wd_expired_s;
        end
      end
      default: begin
        capture_s = 1'b0;
        abort_s   = 1'b0;
      end
    endcase
  end

  // Inter-run delay counter restarts from zero every time WAIT_DLY is entered.
  always_ff @(posedge clk_out1 or negedge rst_n) begin
    if (!rst_n)                       dly_cnt_r <= 16'd0;
    else if (state_r == ST_WAIT_DLY)  dly_cnt_r <= dly_cnt_r + 16'd1;
    else                              dly_cnt_r <= 16'd0;
  end

  // Finished edge detector and the registered start pulse.
  always_ff @(posedge clk_out1 or negedge rst_n) begin
    if (!rst_n) begin
      finished_d_r <= 1'b0;
      meas_start_r <= 1'b0;
    end else begin
      finished_d_r <= meas_finished;
      meas_start_r <= (next_state_s == ST_ARM);
    end
  end

  // Result bank only loads on a finished edge, so it stays frozen throughout HOLD.
  always_ff @(posedge clk_out1 or negedge rst_n) begin
    if (!rst_n) begin
      res_time_r <= {CNT_W{1'b0}};
      res_cnt1_r <= {CNT_W{1'b0}};
      res_cnt2_r <= {CNT_W{1'b0}};
      res_cnt3_r <= {CNT_W{1'b0}};
    end else if (capture_s) begin
      res_time_r <= time_cnt;
      res_cnt1_r <= sig_cnt1;
      res_cnt2_r <= sig_cnt2;
      res_cnt3_r <= sig_cnt3;
    end else begin
      res_time_r <= res_time_r;
      res_cnt1_r <= res_cnt1_r;
      res_cnt2_r <= res_cnt2_r;
      res_cnt3_r <= res_cnt3_r;
    end
  end

  // Handshake, completed-run count, sticky watchdog error and activity LED.
  always_ff @(posedge clk_out1 or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r   <= 1'b0;
      run_count_r   <= 16'd0;
      timeout_err_r <= 1'b0;
      led_on_r      <= 1'b0;
    end else begin
      if (capture_s)     res_valid_r <= 1'b1;
      else if (accept_s) res_valid_r <= 1'b0;
      else               res_valid_r <= res_valid_r;

      if (accept_s) run_count_r <= run_count_r + 16'd1;
      else          run_count_r <= run_count_r;

      if (abort_s)       timeout_err_r <= 1'b1;
      else if (accept_s) timeout_err_r <= 1'b0;
      else               timeout_err_r <= timeout_err_r;

      if (state_r == ST_ARM) led_on_r <= 1'b1;
      else                   led_on_r <= led_on_r;
    end
  end

  assign meas_start  = meas_start_r;
  assign res_valid   = res_valid_r;
  assign res_time    = res_time_r;
  assign res_cnt1    = res_cnt1_r;
  assign res_cnt2    = res_cnt2_r;
  assign res_cnt3    = res_cnt3_r;
  assign run_count   = run_count_r;
  assign timeout_err = timeout_err_r;
  assign led_on      = led_on_r;

endmodule

// File: tb/tb_freq_meas_sequencer.sv
// Directed bench for freq_meas_sequencer with START_DELAY=4 and TIMEOUT=20.
module tb_freq_meas_sequencer;

  logic        clk_out1;
  logic        rst_n;
  logic        enable;
  logic        meas_start;
  logic        meas_busy;
  logic        meas_finished;
  logic [31:0] time_cnt, sig_cnt1, sig_cnt2, sig_cnt3;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_time, res_cnt1, res_cnt2, res_cnt3;
  logic [15:0] run_count;
  logic        timeout_err;
  logic        led_on;

  int total;
  int bad;

  freq_meas_sequencer #(
    .CNT_W       (32),
    .START_DELAY (16'd4),
    .TIMEOUT     (32'd20)
  ) dut (
    .clk_out1      (clk_out1),
    .rst_n         (rst_n),
    .enable        (enable),
    .meas_start    (meas_start),
    .meas_busy     (meas_busy),
    .meas_finished (meas_finished),
    .time_cnt      (time_cnt),
    .sig_cnt1      (sig_cnt1),
    .sig_cnt2      (sig_cnt2),
    .sig_cnt3      (sig_cnt3),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_time      (res_time),
    .res_cnt1      (res_cnt1),
    .res_cnt2      (res_cnt2),
    .res_cnt3      (res_cnt3),
    .run_count     (run_count),
    .timeout_err   (timeout_err),
    .led_on        (led_on)
  );

  initial clk_out1 = 1'b0;
  always #5 clk_out1 = ~clk_out1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  // One active edge, then park on the falling edge for sampling and driving.
  task automatic step();
    @(posedge clk_out1);
    @(negedge clk_out1);
  endtask

  task automatic wait_start(input int max_cyc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      step();
      seen = meas_start;
    end
    chk("start_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic finish_run(input logic [31:0] t, input logic [31:0] c1,
                            input logic [31:0] c2, input logic [31:0] c3);
    meas_finished = 1'b1;
    time_cnt = t; sig_cnt1 = c1; sig_cnt2 = c2; sig_cnt3 = c3;
  endtask

  initial begin
    int viol;
    int starts;
    total = 0; bad = 0;
    rst_n = 1'b0; enable = 1'b0; meas_busy = 1'b0; meas_finished = 1'b0;
    res_ready = 1'b1;
    time_cnt = 32'd0; sig_cnt1 = 32'd0; sig_cnt2 = 32'd0; sig_cnt3 = 32'd0;

    step(); step();
    chk("rst_start",  meas_start,  1'b0);
    chk("rst_valid",  res_valid,   1'b0);
    chk("rst_count",  run_count,   16'd0);
    chk("rst_tmo",    timeout_err, 1'b0);
    chk("rst_led",    led_on,      1'b0);
    chk("rst_time",   res_time,    32'd0);
    rst_n = 1'b1;

    // Test 1: start pulse lands on edge 5 after enable, finished 10 clks later.
    enable = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("t1_start_e%0d", i), meas_start, (i == 5) ? 32'd1 : 32'd0);
    end
    step();
    chk("t1_start_pulse", meas_start, 1'b0);
    chk("t1_led",         led_on,     1'b1);
    for (int i = 0; i < 8; i++) step();
    finish_run(32'h0000_1000, 32'hA1A1_0001, 32'hA2A2_0002, 32'hA3A3_0003);
    step();
    chk("t1_valid",  res_valid, 1'b1);
    chk("t1_cnt1",   res_cnt1,  32'hA1A1_0001);
    chk("t1_time",   res_time,  32'h0000_1000);
    chk("t1_cnt3",   res_cnt3,  32'hA3A3_0003);
    meas_finished = 1'b0;
    sig_cnt1 = 32'hDEAD_BEEF;
    step();
    chk("t1_valid_pulse", res_valid, 1'b0);
    chk("t1_runcnt",      run_count, 16'd1);
    chk("t1_cnt1_held",   res_cnt1,  32'hA1A1_0001);

    // Test 2: backpressure for 50 clks.
    res_ready = 1'b0;
    wait_start(20);
    step(); step(); step();
    finish_run(32'h0000_2000, 32'hB1B1_0001, 32'hB2B2_0002, 32'hB3B3_0003);
    step();
    chk("t2_valid", res_valid, 1'b1);
    meas_finished = 1'b0;
    time_cnt = 32'h1234_5678; sig_cnt1 = 32'h8765_4321;
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (res_valid !== 1'b1 || meas_start !== 1'b0 ||
          res_cnt1 !== 32'hB1B1_0001 || res_time !== 32'h0000_2000) viol++;
    end
    chk("t2_bp_stable", viol,      32'd0);
    chk("t2_runcnt_bp", run_count, 16'd1);
    res_ready = 1'b1;
    step();
    chk("t2_valid_drop", res_valid, 1'b0);
    chk("t2_runcnt",     run_count, 16'd2);

    // Test 3: watchdog abort, restart, and error cleared by a good run.
    wait_start(20);
    for (int i = 1; i <= 25; i++) begin
      step();
      if (i == 20) chk("t3_tmo_before", timeout_err, 1'b0);
      if (i == 21) chk("t3_tmo_set",    timeout_err, 1'b1);
      if (i == 24) chk("t3_no_early",   meas_start,  1'b0);
      if (i == 25) chk("t3_restart",    meas_start,  1'b1);
    end
    step(); step();
    finish_run(32'h0000_3000, 32'hC1C1_0001, 32'hC2C2_0002, 32'hC3C3_0003);
    step();
    chk("t3_valid",    res_valid,   1'b1);
    chk("t3_tmo_kept", timeout_err, 1'b1);
    meas_finished = 1'b0;
    step();
    chk("t3_tmo_clr", timeout_err, 1'b0);
    chk("t3_runcnt",  run_count,   16'd3);

    // Test 4: enable dropped mid-run, result still delivered, no re-arm.
    wait_start(20);
    step(); step(); step();
    enable = 1'b0;
    step(); step();
    finish_run(32'h0000_4000, 32'hD1D1_0001, 32'hD2D2_0002, 32'hD3D3_0003);
    step();
    chk("t4_valid", res_valid, 1'b1);
    chk("t4_cnt2",  res_cnt2,  32'hD2D2_0002);
    meas_finished = 1'b0;
    step();
    chk("t4_runcnt", run_count, 16'd4);
    starts = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (meas_start === 1'b1) starts++;
    end
    chk("t4_no_rearm", starts, 32'd0);

    // Test 5: asynchronous reset while holding a result.
    enable = 1'b1; res_ready = 1'b0;
    wait_start(20);
    step(); step();
    finish_run(32'h0000_5000, 32'hE1E1_0001, 32'hE2E2_0002, 32'hE3E3_0003);
    step();
    chk("t5_valid", res_valid, 1'b1);
    meas_finished = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid",  res_valid,   1'b0);
    chk("t5_rst_led",    led_on,      1'b0);
    chk("t5_rst_count",  run_count,   16'd0);
    chk("t5_rst_cnt3",   res_cnt3,    32'd0);
    chk("t5_rst_tmo",    timeout_err, 1'b0);
    enable = 1'b0;
    @(negedge clk_out1);
    rst_n = 1'b1;
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (meas_start === 1'b1) starts++;
    end
    chk("t5_idle_starts", starts, 32'd0);
    chk("t5_led_off",     led_on, 1'b0);

    // Test 6: run_count wraps from 0xFFFF to 0.
    force dut.run_count_r = 16'hFFFF;
    #1;
    release dut.run_count_r;
    #1;
    chk("t6_preload", run_count, 16'hFFFF);
    enable = 1'b1; res_ready = 1'b1;
    wait_start(20);
    step(); step();
    finish_run(32'h0000_6000, 32'hF1F1_0001, 32'hF2F2_0002, 32'hF3F3_0003);
    step();
    chk("t6_valid", res_valid, 1'b1);
    meas_finished = 1'b0;
    step();
    chk("t6_wrap", run_count, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
